// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational 32-bit ALU between two requesters.
// Optional feature macro ALU_SCHED_MUL_EN: ctrl 4'b1000 becomes a 32-cycle-pair shift/add multiply.
module alu_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_ctrl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamnt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_ctrl,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamnt,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic [7:0]  resp_status,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [4:0]  alu_shamnt,
    input  logic [31:0] alu_result,
    input  logic [7:0]  alu_status,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
`ifdef ALU_SCHED_MUL_EN
    localparam logic [2:0] ST_MUL_SETUP = 3'd4;
    localparam logic [2:0] ST_MUL_EXEC  = 3'd5;
    localparam logic [3:0] CTRL_ADD     = 4'h2;
`endif
    localparam logic [3:0] CTRL_NOP = 4'hF;
    localparam logic [3:0] CTRL_MUL = 4'h8;
    localparam logic [3:0] CTRL_BAD = 4'h9;

    logic [2:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [4:0]  sh_q, sh_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [31:0] resp_result_q, resp_result_d;
    logic [7:0]  resp_status_q, resp_status_d;

`ifdef ALU_SCHED_MUL_EN
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [4:0]  mul_idx_q, mul_idx_d;
    logic        mul_carry_q, mul_carry_d;
    logic        mul_ovf_q, mul_ovf_d;
    logic [63:0] mul_wide;
    logic [4:0]  mul_idx_nxt;
    logic        mul_carry_acc, mul_ovf_acc;
`endif

    logic        idle;
    logic        sel_id;
    logic [3:0]  sel_ctrl;
    logic [31:0] sel_a, sel_b;
    logic [4:0]  sel_sh;
    logic        sel_unsup;
    logic        unused_status_lsbs;

    assign unused_status_lsbs = ^alu_status[1:0];

    assign idle = (state_q == ST_IDLE);
    assign busy = ~idle;

    // On a tie the requester not granted last wins; a lone valid always wins.
    always_comb begin
        sel_id = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_id = ~last_grant_q;
        end else if (req1_valid) begin
            sel_id = 1'b1;
        end
    end

    // Only the tie winner sees ready, so the loser never believes it was taken.
    assign req0_ready = idle & rst_n & ~(req1_valid & sel_id);
    assign req1_ready = idle & rst_n & ~(req0_valid & ~sel_id);

    assign sel_ctrl = sel_id ? req1_ctrl   : req0_ctrl;
    assign sel_a    = sel_id ? req1_a      : req0_a;
    assign sel_b    = sel_id ? req1_b      : req0_b;
    assign sel_sh   = sel_id ? req1_shamnt : req0_shamnt;

`ifdef ALU_SCHED_MUL_EN
    assign sel_unsup = (sel_ctrl == CTRL_BAD);
`else
    assign sel_unsup = (sel_ctrl == CTRL_BAD) || (sel_ctrl == CTRL_MUL);
`endif

    always_comb begin
        alu_ctrl = CTRL_NOP;
        case (state_q)
            ST_EXEC:     alu_ctrl = ctrl_q;
`ifdef ALU_SCHED_MUL_EN
            ST_MUL_EXEC: alu_ctrl = CTRL_ADD;
`endif
            default:     alu_ctrl = CTRL_NOP;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        ctrl_d        = ctrl_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        sh_d          = sh_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_status_d = resp_status_q;
`ifdef ALU_SCHED_MUL_EN
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_idx_d     = mul_idx_q;
        mul_carry_d   = mul_carry_q;
        mul_ovf_d     = mul_ovf_q;
        mul_idx_nxt   = mul_idx_q + 5'd1;
        mul_wide      = {32'h0, mul_a_q} << mul_idx_q;
        mul_carry_acc = mul_carry_q | alu_status[5];
        mul_ovf_acc   = mul_ovf_q | alu_status[5] |
                        (mul_b_q[mul_idx_q] & (|mul_wide[63:32]));
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    last_grant_d = sel_id;
                    resp_id_d    = sel_id;
                    ctrl_d       = sel_ctrl;
                    if (sel_unsup) begin
                        resp_result_d = 32'h0;
                        resp_status_d = 8'b1000_0010;
                        state_d       = ST_RESP;
                    end
`ifdef ALU_SCHED_MUL_EN
                    else if (sel_ctrl == CTRL_MUL) begin
                        mul_a_d     = sel_a;
                        mul_b_d     = sel_b;
                        mul_idx_d   = 5'd0;
                        mul_carry_d = 1'b0;
                        mul_ovf_d   = 1'b0;
                        op1_d       = 32'h0;
                        op2_d       = sel_b[0] ? sel_a : 32'h0;
                        state_d     = ST_MUL_SETUP;
                    end
`endif
                    else begin
                        op1_d   = sel_a;
                        op2_d   = sel_b;
                        sh_d    = sel_sh;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: state_d = ST_EXEC;
            ST_EXEC: begin
                resp_result_d = alu_result;
                resp_status_d = {alu_status[7:2], 2'b00};
                state_d       = ST_RESP;
            end
            // First RESP cycle registers the response; it then holds until taken.
            ST_RESP: begin
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
`ifdef ALU_SCHED_MUL_EN
            ST_MUL_SETUP: state_d = ST_MUL_EXEC;
            ST_MUL_EXEC: begin
                op1_d       = alu_result;
                mul_carry_d = mul_carry_acc;
                mul_ovf_d   = mul_ovf_acc;
                if (mul_idx_q == 5'd31) begin
                    resp_result_d = alu_result;
                    resp_status_d = {alu_status[7], mul_ovf_acc, mul_carry_acc,
                                     alu_status[4], alu_status[3], 3'b000};
                    state_d       = ST_RESP;
                end else begin
                    mul_idx_d = mul_idx_nxt;
                    op2_d     = mul_b_q[mul_idx_nxt] ? (mul_a_q << mul_idx_nxt) : 32'h0;
                    state_d   = ST_MUL_SETUP;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            ctrl_q        <= CTRL_NOP;
            op1_q         <= 32'h0;
            op2_q         <= 32'h0;
            sh_q          <= 5'h0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= 32'h0;
            resp_status_q <= 8'h0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            ctrl_q        <= ctrl_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            sh_q          <= sh_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_status_q <= resp_status_d;
        end
    end

`ifdef ALU_SCHED_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q     <= 32'h0;
            mul_b_q     <= 32'h0;
            mul_idx_q   <= 5'h0;
            mul_carry_q <= 1'b0;
            mul_ovf_q   <= 1'b0;
        end else begin
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_idx_q   <= mul_idx_d;
            mul_carry_q <= mul_carry_d;
            mul_ovf_q   <= mul_ovf_d;
        end
    end
`endif

    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_shamnt  = sh_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_status = resp_status_q;

endmodule
